qam_codeword_packer: RTL and testbench

Modulation mapper and codeword packer feeding the layer mapper. Accepts 2- or 4-bit groups over a valid/ready handshake and maps each group to one complex symbol in Q1.15 (QPSK, or 16QAM per TS 38.211). It packs 16 consecutive symbols into the `codeword0`/`codeword1` pair, then presents the pair with a valid/ready handshake. Outputs connect directly to the layer mapper's `codeword0`/`codeword1` inputs.

---
 rtl/qam_codeword_packer.sv | 132 +++++++++++++
 tb/tb_qam_codeword_packer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qam_codeword_packer.sv
// qam_codeword_packer: maps 2/4-bit groups to Q1.15 QPSK/16QAM symbols and packs 16 of them into codeword0/codeword1.
// Latency: cw_valid rises the cycle after the 16th group is accepted. Backpressure: bit_ready is low while the pair waits for cw_ready.
// Build option: define QAM16_EN to honour mod_sel and bit_in[3:2]; otherwise every block is QPSK.
module qam_codeword_packer #(
    parameter int IW   = 16,
    parameter int SYMS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mod_sel,
    input  logic [3:0]           bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic [0:SYMS*2*IW-1] codeword0,
    output logic [0:SYMS*2*IW-1] codeword1,
    output logic                 cw_valid,
    input  logic                 cw_ready
);
    localparam int SW = 2 * IW;

    localparam logic [1:0] FILL0 = 2'd0;
    localparam logic [1:0] FILL1 = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;

    localparam logic [IW-1:0] QPSK_P = 16'h5A82;
    localparam logic [IW-1:0] QPSK_N = 16'hA57E;

    logic [1:0]    state;
    logic [2:0]    sc;
    logic          mod_q;
    logic          eff_mod;
    logic          first_grp;
    logic          last_sym;
    logic [IW-1:0] sym_i;
    logic [IW-1:0] sym_q;
    logic [SW-1:0] sym;
    logic [7:0]    sym_base;

    assign bit_ready = (state != OUT);
    assign cw_valid  = (state == OUT);
    assign first_grp = (state == FILL0) && (sc == 3'd0);
    assign last_sym  = (sc == 3'(SYMS - 1));
    assign sym_base  = {sc, 5'b00000};

`ifdef QAM16_EN
    localparam logic [IW-1:0] QAM_P1 = 16'h287A;
    localparam logic [IW-1:0] QAM_N1 = 16'hD786;
    localparam logic [IW-1:0] QAM_P3 = 16'h796E;
    localparam logic [IW-1:0] QAM_N3 = 16'h8692;

    function automatic logic [IW-1:0] qam_lvl(input logic neg, input logic big);
        logic [IW-1:0] v;
        case ({neg, big})
            2'b00:   v = QAM_P1;
            2'b01:   v = QAM_P3;
            2'b10:   v = QAM_N1;
            default: v = QAM_N3;
        endcase
        return v;
    endfunction

    // The first group of a block maps with the live mod_sel; mod_q captures it for the rest.
    assign eff_mod = first_grp ? mod_sel : mod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q <= 1'b0;
        end else if (first_grp && bit_valid) begin
            mod_q <= mod_sel;
        end
    end
`else
    wire unused_in = &{1'b0, mod_sel, bit_in[3:2]};

    assign mod_q   = 1'b0;
    assign eff_mod = mod_q;
`endif

    always_comb begin
        sym_i = bit_in[0] ? QPSK_N : QPSK_P;
        sym_q = bit_in[1] ? QPSK_N : QPSK_P;
`ifdef QAM16_EN
        if (eff_mod) begin
            sym_i = qam_lvl(bit_in[0], bit_in[2]);
            sym_q = qam_lvl(bit_in[1], bit_in[3]);
        end
`else
        if (eff_mod) begin
            sym_i = QPSK_P;
            sym_q = QPSK_P;
        end
`endif
        sym = {sym_i, sym_q};
    end

    // Codewords are written in place; sc wraps from 7 to 0 on its own at the codeword boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL0;
            sc        <= 3'd0;
            codeword0 <= '0;
            codeword1 <= '0;
        end else begin
            case (state)
                FILL0: begin
                    if (bit_valid) begin
                        codeword0[sym_base +: SW] <= sym;
                        sc <= sc + 3'd1;
                        if (last_sym) state <= FILL1;
                    end
                end
                FILL1: begin
                    if (bit_valid) begin
                        codeword1[sym_base +: SW] <= sym;
                        sc <= sc + 3'd1;
                        if (last_sym) state <= OUT;
                    end
                end
                OUT: begin
                    if (cw_ready) begin
                        state <= FILL0;
                        sc    <= 3'd0;
                    end
                end
                default: begin
                    state <= FILL0;
                    sc    <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qam_codeword_packer.sv
// Bench for qam_codeword_packer: directed vector table, reset corner cases and randomized blocks
// checked against an arithmetic mapping model.
module tb_qam_codeword_packer;
    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         mod_sel   = 1'b0;
    logic [3:0]   bit_in    = 4'h0;
    logic         bit_valid = 1'b0;
    logic         cw_ready  = 1'b0;
    logic         bit_ready;
    logic         cw_valid;
    logic [0:255] codeword0;
    logic [0:255] codeword1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    qam_codeword_packer #(.IW(16), .SYMS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mod_sel   (mod_sel),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .codeword0 (codeword0),
        .codeword1 (codeword1),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready)
    );

    typedef struct {
        logic        mod;
        logic [63:0] grps;   // group k in grps[4k+3:4k]
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s15;
    } vec_t;

    vec_t vecs[4];

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_w(input string name, input logic [0:255] act, input logic [0:255] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One component: sign from bs, magnitude from bm (16QAM only), value in Q1.15.
    function automatic logic [15:0] ref_comp(input logic m, input logic bs, input logic bm);
        int v;
        v = 1 - 2 * int'(bs);
        if (m) v = v * (2 - (1 - 2 * int'(bm))) * 10362;
        else   v = v * 23170;
        return v[15:0];
    endfunction

    function automatic logic [31:0] ref_sym(input logic m, input logic [3:0] g);
        logic eff;
`ifdef QAM16_EN
        eff = m;
`else
        eff = 1'b0;
`endif
        return {ref_comp(eff, g[0], g[2]), ref_comp(eff, g[1], g[3])};
    endfunction

    // Called at a negedge; returns at the negedge after the group was accepted.
    task automatic push(input logic [3:0] g, input logic m);
        int t;
        t = 0;
        bit_in = g; mod_sel = m; bit_valid = 1'b1;
        while (!bit_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check1("push_timeout bit_ready", bit_ready, 1'b1);
        end else begin
            @(negedge clk);
        end
        bit_valid = 1'b0;
        mod_sel   = 1'($urandom);
    endtask

    task automatic run_block(input string tag, input logic m, input logic [63:0] grps,
                             input int gap_pct, input int hold,
                             output logic [0:255] c0, output logic [0:255] c1);
        logic [0:255] e0;
        logic [0:255] e1;
        logic [3:0]   g;
        e0 = '0;
        e1 = '0;
        for (int k = 0; k < 16; k++) begin
            g = grps[4*k +: 4];
            while (int'($urandom_range(99)) < gap_pct) begin
                cw_ready = 1'($urandom);
                @(negedge clk);
            end
            cw_ready = 1'($urandom);
            // mod_sel is randomized after the first group; the block must keep its first mapping
            push(g, (k == 0) ? m : 1'($urandom));
            if (k < 8) e0[32*k +: 32] = ref_sym(m, g);
            else       e1[32*(k-8) +: 32] = ref_sym(m, g);
        end
        check1({tag, " cw_valid after 16th accept"}, cw_valid, 1'b1);
        check_w({tag, " codeword0"}, codeword0, e0);
        check_w({tag, " codeword1"}, codeword1, e1);
        c0 = codeword0;
        c1 = codeword1;
        cw_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check1({tag, " hold cw_valid"}, cw_valid, 1'b1);
            check1({tag, " hold bit_ready"}, bit_ready, 1'b0);
            check_w({tag, " hold codeword0"}, codeword0, e0);
            check_w({tag, " hold codeword1"}, codeword1, e1);
        end
        cw_ready = 1'b1;
        @(negedge clk);
        cw_ready = 1'b0;
        check1({tag, " cw_valid after accept"}, cw_valid, 1'b0);
        check1({tag, " bit_ready after accept"}, bit_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:255] c0;
        logic [0:255] c1;
        logic [0:255] all_n;

        vecs[0] = '{1'b0, 64'h0000_0000_0000_0000, 32'h5A825A82, 32'h5A825A82, 32'h5A825A82};
        vecs[1] = '{1'b0, 64'h3210_3210_3210_3210, 32'h5A825A82, 32'hA57E5A82, 32'hA57EA57E};
`ifdef QAM16_EN
        vecs[2] = '{1'b1, 64'h0000_0000_0000_000F, 32'h86928692, 32'h287A287A, 32'h287A287A};
        vecs[3] = '{1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 32'h8692287A, 32'h287A8692, 32'h287A8692};
`else
        vecs[2] = '{1'b1, 64'h0000_0000_0000_000F, 32'hA57EA57E, 32'h5A825A82, 32'h5A825A82};
        vecs[3] = '{1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 32'hA57E5A82, 32'h5A82A57E, 32'h5A82A57E};
`endif

        // Reset state
        #22;
        check1("reset cw_valid", cw_valid, 1'b0);
        check_w("reset codeword0", codeword0, '0);
        check_w("reset codeword1", codeword1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check1("post-reset bit_ready", bit_ready, 1'b1);
        check1("post-reset cw_valid", cw_valid, 1'b0);

        // Directed vector table
        for (int i = 0; i < 4; i++) begin
            run_block($sformatf("vec%0d", i), vecs[i].mod, vecs[i].grps,
                      (i == 1) ? 0 : 25, (i == 0) ? 5 : ((i == 1) ? 0 : 2), c0, c1);
            check32($sformatf("vec%0d sym0", i), c0[0 +: 32], vecs[i].s0);
            check32($sformatf("vec%0d sym1", i), c0[32 +: 32], vecs[i].s1);
            check32($sformatf("vec%0d sym15", i), c1[224 +: 32], vecs[i].s15);
        end

        // Reset after 5 groups discards the partial block
        for (int k = 0; k < 5; k++) push(4'h5, 1'b1);
        check1("partial block bit_ready", bit_ready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_w("mid-block reset codeword0", codeword0, '0);
        check1("mid-block reset cw_valid", cw_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check1("mid-block reset bit_ready", bit_ready, 1'b1);
        for (int k = 0; k < 8; k++) all_n[32*k +: 32] = 32'hA57EA57E;
        run_block("after-reset qpsk 11", 1'b0, 64'h3333_3333_3333_3333, 20, 1, c0, c1);
        check_w("after-reset pair word0", c0, all_n);
        check_w("after-reset pair word1", c1, all_n);

        // Randomized blocks
        for (int b = 0; b < 12; b++) begin
            run_block($sformatf("rand%0d", b), 1'($urandom), {$urandom, $urandom},
                      30, int'($urandom_range(5)), c0, c1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
